// File: rtl/apb_ctrl_pkg.sv
// Shared types and helpers for the parametrised APB master controller.
package apb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_NUM_SLV     = 3;
    localparam int unsigned DEF_TIMEOUT_CYC = 16;

    // Widest select vector the one-hot helper accepts
    localparam int unsigned MAX_SLV = 64;

    // True when exactly one bit of v is set
    function automatic logic is_onehot(input logic [MAX_SLV-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/apb_ctrl_param_if.sv
// Bridge-side request bus and APB bus of the controller, grouped as one interface.
// master: controller view; slave: environment (AHB slave interface + APB peripherals).
interface apb_ctrl_param_if
    import apb_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned NUM_SLV = DEF_NUM_SLV
);
    logic               valid;
    logic               Hwrite;
    logic [ADDR_W-1:0]  Haddr;
    logic [DATA_W-1:0]  Hwdata;
    logic [NUM_SLV-1:0] tempselx;
    logic [DATA_W-1:0]  Prdata;
    logic               Pready;
    logic               Pslverr;
    logic               Pwrite;
    logic               Penable;
    logic [NUM_SLV-1:0] Pselx;
    logic [ADDR_W-1:0]  Paddr;
    logic [DATA_W-1:0]  Pwdata;
    logic               Hreadyout;
    logic [DATA_W-1:0]  Hrdata;
    logic               Hresp;

    modport master (
        input  valid, Hwrite, Haddr, Hwdata, tempselx, Prdata, Pready, Pslverr,
        output Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout, Hrdata, Hresp
    );

    modport slave (
        output valid, Hwrite, Haddr, Hwdata, tempselx, Prdata, Pready, Pslverr,
        input  Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout, Hrdata, Hresp
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Consecutive wait-state counter for the APB ACCESS phase; saturates at TIMEOUT_CYC.
module apb_wait_timer
    import apb_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    input  logic clear,
    output logic expired
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC));

    // Count wait cycles, clear outside ACCESS, hold once the limit is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count_en && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/apb_ctrl_param.sv
// Parametrised APB master controller for the AHB-to-APB bridge.
// Runs SETUP/ACCESS on one of NUM_SLV peripherals, honours Pready wait states,
// returns Pslverr, flags select decode errors.
// Optional feature macro: APB_CTRL_TIMEOUT_EN (abort after TIMEOUT_CYC wait cycles).
module apb_ctrl_param
    import apb_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned NUM_SLV     = DEF_NUM_SLV,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             Hclk,
    input  logic             Hresetn,
    apb_ctrl_param_if.master bus
);

    if (NUM_SLV < 1 || NUM_SLV > MAX_SLV || TIMEOUT_CYC < 1) begin : g_param_check
        $error("apb_ctrl_param: unsupported NUM_SLV or TIMEOUT_CYC");
    end

    apb_state_e         state_q, state_d;

    logic [ADDR_W-1:0]  req_addr;
    logic               req_write;
    logic [DATA_W-1:0]  req_wdata;
    logic [NUM_SLV-1:0] req_sel;

    logic [NUM_SLV-1:0] pselx_q;
    logic               penable_q;
    logic               hreadyout_q;
    logic [DATA_W-1:0]  hrdata_q;
    logic               hresp_q;

    logic               sel_ok;
    logic               accept;
    logic               decode_err;
    logic               complete;
    logic               abort;
    logic               wait_expired;

    assign sel_ok = is_onehot(MAX_SLV'(bus.tempselx));

`ifdef APB_CTRL_TIMEOUT_EN
    logic timer_en;
    logic timer_clr;

    assign timer_en  = (state_q == ACCESS) && !bus.Pready;
    assign timer_clr = (state_q != ACCESS);

    apb_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk      (Hclk),
        .rst_n    (Hresetn),
        .count_en (timer_en),
        .clear    (timer_clr),
        .expired  (wait_expired)
    );
`else
    assign wait_expired = 1'b0;
`endif

    // State register
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and transfer events
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        decode_err = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    if (sel_ok) begin
                        accept  = 1'b1;
                        state_d = SETUP;
                    end else begin
                        decode_err = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A ready slave wins over an expiring timeout on the same edge
                if (bus.Pready) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (wait_expired) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request register: captured once at accept, held through the transfer and after
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            req_addr  <= '0;
            req_write <= 1'b0;
            req_wdata <= '0;
            req_sel   <= '0;
        end else if (accept) begin
            req_addr  <= bus.Haddr;
            req_write <= bus.Hwrite;
            req_wdata <= bus.Hwdata;
            req_sel   <= bus.tempselx;
        end
    end

    // Registered APB control and ready, derived from the upcoming state
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
        end else begin
            pselx_q     <= (state_d == IDLE) ? '0 : (accept ? bus.tempselx : req_sel);
            penable_q   <= (state_d == ACCESS);
            hreadyout_q <= (state_d == IDLE);
        end
    end

    // Response capture: completion, decode error or timeout abort
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            hrdata_q <= '0;
            hresp_q  <= 1'b0;
        end else if (complete) begin
            hresp_q <= bus.Pslverr;
            if (!req_write) begin
                hrdata_q <= bus.Prdata;
            end
        end else if (decode_err || abort) begin
            hresp_q <= 1'b1;
        end
    end

    assign bus.Paddr     = req_addr;
    assign bus.Pwrite    = req_write;
    assign bus.Pwdata    = req_wdata;
    assign bus.Pselx     = pselx_q;
    assign bus.Penable   = penable_q;
    assign bus.Hreadyout = hreadyout_q;
    assign bus.Hrdata    = hrdata_q;
    assign bus.Hresp     = hresp_q;

endmodule
